// File: rtl/game_pkg.sv
// Shared state codes and constants for the game flow controller.
package game_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_MAZE = 2'b01;
   localparam logic [1:0] ST_WIN  = 2'b10;
   localparam logic [1:0] ST_LED  = 2'b11;

   localparam logic [3:0] STATUS_DONE   = 4'hF;
   localparam logic [3:0] WIN_COUNT_MAX = 4'hF;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StMaze = ST_MAZE,
      StWin  = ST_WIN,
      StLed  = ST_LED
   } game_state_e;

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchroniser, consecutive-cycle debouncer and rising-edge pulse.
module button_debounce
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic pulse_o
);

   localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic [1:0]      vld_q;
   logic            arm_q;
   logic            level_q, prev_q, pulse_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         vld_q   <= 2'b00;
         arm_q   <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         // Arm only once the synchronised button has been seen released, so a button
         // held through reset release cannot produce a pulse.
         vld_q <= {vld_q[0], 1'b1};
         if (vld_q[1] && !sync2_q) begin
            arm_q <= 1'b1;
         end
         if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
         prev_q  <= level_q;
         pulse_q <= arm_q & level_q & ~prev_q;
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/game_mode_sequencer.sv
// Master game flow controller: debounced buttons select MAZE/LED, completion shows WIN.
// Optional GAME_ABORT_EN: debounced L+R held in MAZE/LED aborts back to IDLE.
module game_mode_sequencer
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned WIN_HOLD_CYCLES = 500000000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BTNL,
   input  logic       BTNC,
   input  logic       BTNR,
   input  logic [3:0] MAZE_STATUS,
   input  logic [3:0] LED_STATUS,
   output logic [1:0] MASTER_STATE,
   output logic       MODE_START,
   output logic [2:0] BTN_PULSE,
   output logic [3:0] WIN_COUNT
);

   localparam int unsigned     HoldW    = $clog2(WIN_HOLD_CYCLES) + 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(WIN_HOLD_CYCLES - 1);

   logic lvl_l, lvl_r, unused_lvl_c;
   logic pulse_l, pulse_c, pulse_r;
   logic abort;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .btn_i   (BTNL),
      .level_o (lvl_l),
      .pulse_o (pulse_l)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .btn_i   (BTNC),
      .level_o (unused_lvl_c),
      .pulse_o (pulse_c)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .btn_i   (BTNR),
      .level_o (lvl_r),
      .pulse_o (pulse_r)
   );

`ifdef GAME_ABORT_EN
   assign abort = lvl_l & lvl_r;
`else
   logic unused_lvl;
   assign unused_lvl = lvl_l ^ lvl_r;
   assign abort      = 1'b0;
`endif

   game_state_e      state_q;
   logic [HoldW-1:0] hold_q;
   logic [3:0]       win_cnt_q;
   logic             mode_start_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         win_cnt_q    <= '0;
         mode_start_q <= 1'b0;
      end else begin
         mode_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pulse_c) begin
                  state_q <= StWin;
                  hold_q  <= '0;
               end else if (pulse_l) begin
                  state_q      <= StLed;
                  mode_start_q <= 1'b1;
               end else if (pulse_r) begin
                  state_q      <= StMaze;
                  mode_start_q <= 1'b1;
               end
            end
            StMaze, StLed: begin
               if (abort) begin
                  state_q <= StIdle;
               end else if ((state_q == StMaze ? MAZE_STATUS : LED_STATUS) == STATUS_DONE) begin
                  state_q <= StWin;
                  hold_q  <= '0;
                  if (win_cnt_q != WIN_COUNT_MAX) begin
                     win_cnt_q <= win_cnt_q + 4'd1;
                  end
               end
            end
            StWin: begin
               if (hold_q == HoldLast) begin
                  state_q <= StIdle;
               end else begin
                  hold_q <= hold_q + HoldW'(1);
               end
            end
         endcase
      end
   end

   assign MASTER_STATE = state_q;
   assign MODE_START   = mode_start_q;
   assign BTN_PULSE    = {pulse_l, pulse_c, pulse_r};
   assign WIN_COUNT    = win_cnt_q;

endmodule

// File: tb/tb_game_mode_sequencer.sv
// Randomised bench for game_mode_sequencer against a history-based behavioural model.
// Honours GAME_ABORT_EN the same way as the design.
module tb_game_mode_sequencer;

   localparam int D = 4;
   localparam int H = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] btn = 3'b000;
   logic [3:0] maze_status = 4'h0;
   logic [3:0] led_status = 4'h0;
   logic [1:0] master_state;
   logic       mode_start;
   logic [2:0] btn_pulse;
   logic [3:0] win_count;

   game_mode_sequencer #(
      .DEBOUNCE_CYCLES (D),
      .WIN_HOLD_CYCLES (H)
   ) dut (
      .CLK          (clk),
      .RESET        (rst_n),
      .BTNL         (btn[2]),
      .BTNC         (btn[1]),
      .BTNR         (btn[0]),
      .MAZE_STATUS  (maze_status),
      .LED_STATUS   (led_status),
      .MASTER_STATE (master_state),
      .MODE_START   (mode_start),
      .BTN_PULSE    (btn_pulse),
      .WIN_COUNT    (win_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Staged inputs, applied on the next falling edge.
   logic [2:0] nx_btn = 3'b000;
   logic [3:0] nx_maze = 4'h0;
   logic [3:0] nx_led = 4'h0;

   // Model state: 0 idle, 1 maze, 2 win, 3 led.
   logic [2:0] m_hist[$];
   logic [2:0] m_lvl, m_rose, m_armed, m_pulse;
   int         m_state, m_hold, m_wins;
   logic       m_start;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      m_lvl   = '0;
      m_rose  = '0;
      m_armed = '0;
      m_pulse = '0;
      m_state = 0;
      m_hold  = 0;
      m_wins  = 0;
      m_start = 1'b0;
   endtask

   // Synchronised value the debouncer sees at edge j (1-based since reset release).
   function automatic logic delayed(input int b, input int j);
      if (j < 3) return 1'b0;
      return m_hist[j-3][b];
   endfunction

   task automatic model_update();
      logic [2:0] pulse_pre, lvl_pre;
      logic       abort, flip;
      int         k;
      pulse_pre = m_pulse;
      lvl_pre   = m_lvl;
      abort     = 1'b0;
`ifdef GAME_ABORT_EN
      abort = lvl_pre[2] & lvl_pre[0];
`endif
      m_start = 1'b0;
      case (m_state)
         0: begin
            if (pulse_pre[1]) begin
               m_state = 2;
               m_hold  = H;
            end else if (pulse_pre[2]) begin
               m_state = 3;
               m_start = 1'b1;
            end else if (pulse_pre[0]) begin
               m_state = 1;
               m_start = 1'b1;
            end
         end
         1, 3: begin
            if (abort) begin
               m_state = 0;
            end else if ((m_state == 1 ? maze_status : led_status) == 4'hF) begin
               m_state = 2;
               m_hold  = H;
               if (m_wins < 15) m_wins++;
            end
         end
         default: begin
            m_hold--;
            if (m_hold == 0) m_state = 0;
         end
      endcase
      m_hist.push_back(btn);
      k = m_hist.size();
      for (int b = 0; b < 3; b++) begin
         m_pulse[b] = m_rose[b] & m_armed[b];
         m_rose[b]  = 1'b0;
         flip = (k >= D);
         for (int j = k - D + 1; j <= k; j++) begin
            if (j >= 1 && delayed(b, j) == m_lvl[b]) flip = 1'b0;
         end
         if (flip) begin
            m_lvl[b]  = ~m_lvl[b];
            m_rose[b] = m_lvl[b];
         end
         if (k >= 3 && m_hist[k-3][b] == 1'b0) m_armed[b] = 1'b1;
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_eq("master_state", 32'(master_state), 32'(m_state));
         check_eq("mode_start", 32'(mode_start), 32'(m_start));
         check_eq("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
         check_eq("win_count", 32'(win_count), 32'(m_wins));
         btn         = nx_btn;
         maze_status = nx_maze;
         led_status  = nx_led;
         @(posedge clk);
         model_update();
      end
   endtask

   // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
   task automatic reset_pulse();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_state", 32'(master_state), 32'd0);
      check_eq("rst_start", 32'(mode_start), 32'd0);
      check_eq("rst_pulse", 32'(btn_pulse), 32'd0);
      check_eq("rst_wins", 32'(win_count), 32'd0);
      model_reset();
      btn         = nx_btn;
      maze_status = nx_maze;
      led_status  = nx_led;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [2:0] mask, input int bounce, input int hold);
      for (int i = 0; i < bounce; i++) begin
         nx_btn = (i % 2 == 0) ? mask : 3'b000;
         run_cycles(2);
      end
      nx_btn = mask;
      run_cycles(hold);
      nx_btn = 3'b000;
   endtask

   initial begin
      model_reset();
      reset_pulse();
      run_cycles(100);

      // Bouncy right press selects MAZE.
      press(3'b001, 5, 12);
      run_cycles(10);

      // Maze completion for one cycle, centre presses ignored during WIN.
      nx_maze = 4'hF;
      run_cycles(1);
      nx_maze = 4'($urandom_range(0, 14));
      press(3'b010, 0, 8);
      run_cycles(14);

      // Simultaneous centre and left: centre shortcut to WIN, no win counted.
      press(3'b110, 0, 8);
      run_cycles(25);

      // Enter LED, then hold left+right together.
      press(3'b100, 0, 9);
      run_cycles(8);
      press(3'b101, 0, 12);
      run_cycles(10);
      nx_led = 4'hF;
      run_cycles(1);
      nx_led = 4'h0;
      run_cycles(20);

      // Repeated LED completions drive the win count to saturation.
      for (int g = 0; g < 17; g++) begin
         press(3'b100, $urandom_range(0, 2), 9);
         run_cycles(2);
         nx_led = 4'hF;
         run_cycles(1);
         nx_led = 4'($urandom_range(0, 14));
         run_cycles(18);
      end

      // Free-running random buttons and status.
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 11) == 0) nx_btn[b] = ~nx_btn[b];
         end
         nx_maze = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         nx_led  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         run_cycles(1);
      end

      // Right button held through reset release: no pulse until re-pressed.
      nx_btn  = 3'b001;
      nx_maze = 4'h0;
      nx_led  = 4'h0;
      reset_pulse();
      run_cycles(20);
      nx_btn = 3'b000;
      run_cycles(10);
      press(3'b001, 0, 10);
      run_cycles(4);

      // Complete the maze, then abort the WIN hold with reset.
      nx_maze = 4'hF;
      run_cycles(1);
      nx_maze = 4'h0;
      run_cycles(5);
      reset_pulse();
      run_cycles(20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/game_mode_sequencer.md
Name: game_mode_sequencer

Overview:
Registered master controller for the board game flow. It debounces the three push-buttons, selects which sub-state machine (maze, LED, VGA) owns the game, and forwards clean button pulses to it. It detects completion, holds the VGA win screen for a fixed time, returns to idle, and counts wins for the 7-segment display. It sits at top level and drives MASTER_STATE into MazeSM, LED_displaySM and VGA_displaySM.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz)
WIN_HOLD_CYCLES, 500000000, cycles spent in WIN before returning to IDLE (5 s)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
BTNL  in  1  raw left button, asynchronous to CLK
BTNC  in  1  raw centre button, asynchronous to CLK
BTNR  in  1  raw right button, asynchronous to CLK
MAZE_STATUS  in  4  maze sub-SM status; 4'hF means complete
LED_STATUS  in  4  LED sub-SM status; 4'hF means complete
MASTER_STATE  out  2  00 IDLE, 01 MAZE, 10 WIN, 11 LED
MODE_START  out  1  one-cycle pulse on entry to MAZE or LED
BTN_PULSE  out  3  {L,C,R} debounced rising-edge pulses, 1 cycle each
WIN_COUNT  out  4  completed games, saturating

Behaviour:
- Reset (RESET=0, async): MASTER_STATE=00, MODE_START=0, BTN_PULSE=000, WIN_COUNT=0. Synchronisers, debounced levels, debounce counters and the hold counter clear to 0.
- Per button: a 2-FF synchroniser, then a debouncer.
  - The debounced level flips only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch-free cycle clears the counter.
  - The pulse is asserted in the cycle after the debounced level rises. Falling edges produce no pulse.
- Latency, raw press to pulse: 2 + DEBOUNCE_CYCLES + 1 cycles. Pulse to MASTER_STATE change: 1 clock edge.
- IDLE:
  - pulse C goes to WIN;
  - else pulse L goes to LED;
  - else pulse R goes to MAZE.
  - Priority is C > L > R for simultaneous pulses.
- MAZE: MAZE_STATUS==4'hF sampled on an edge moves to WIN on that edge. Button pulses do not change state.
- LED: LED_STATUS==4'hF moves to WIN, with the same rules as MAZE.
- WIN:
  - The hold counter loads 0 on entry and increments each cycle.
  - When the counter reaches WIN_HOLD_CYCLES-1, the next state is IDLE.
  - Button pulses are ignored throughout WIN.
- WIN_COUNT increments by 1 on each MAZE→WIN or LED→WIN transition and saturates at 4'hF. IDLE→WIN (the C shortcut) does not count.
- MODE_START is high for exactly the first cycle MASTER_STATE shows 01 or 11.
- BTN_PULSE is forwarded in every state, including IDLE and WIN. Sub-SMs gate on MASTER_STATE.
- A status value of 4'hF seen while in IDLE or WIN is ignored.
- Reset asserted mid-game or mid-hold aborts immediately to the reset values. No pulse is generated for buttons held through reset release until they are released and pressed again.
- Counter widths are $clog2(param)+1. Parameter values of 1 or less are illegal.

Optional Feature:
Macro GAME_ABORT_EN.
- Defined: in MAZE or LED, if the debounced L and R levels are both high on an edge, next state is IDLE. This abort takes priority over the status-complete check, and WIN_COUNT is unchanged.
- Undefined: no abort path; MAZE and LED exit only via completion.

Decomposition:
- Package game_pkg holds:
  - state localparams ST_IDLE=2'b00, ST_MAZE=2'b01, ST_WIN=2'b10, ST_LED=2'b11;
  - STATUS_DONE=4'hF;
  - WIN_COUNT_MAX=4'hF.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; synchroniser + debounce + rise pulse) is instantiated three times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and WIN_HOLD_CYCLES=16.
- Reset release, no stimulus → MASTER_STATE=00, WIN_COUNT=0, BTN_PULSE=000 for 100 cycles.
- BTNR bounces 0/1 every 2 cycles for 10 cycles, then held high → exactly one BTN_PULSE[0], 7 cycles after the stable high begins; MASTER_STATE=01 one edge later; MODE_START=1 for 1 cycle.
- In MAZE, MAZE_STATUS=4'hF for 1 cycle → MASTER_STATE=10 next edge, WIN_COUNT=1; returns to 00 after 16 cycles; BTNC pulses during WIN leave the state at 10.
- In IDLE, BTNC and BTNL pressed on the same cycle → MASTER_STATE=10 (C wins); WIN_COUNT stays 0.
- Run 17 LED completions (status 4'hF) → WIN_COUNT=4'hF; no wrap to 0.
- With GAME_ABORT_EN: in LED, hold BTNL+BTNR → MASTER_STATE=00 after debounce, WIN_COUNT unchanged. Without the macro, the same stimulus leaves the state at 11. Reset pulsed mid-WIN → immediate 00.
